// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the two-requester ALU sharing arbiter.
//   - alu_ctrl_e : 4-bit ALUControl encodings understood by the shared ALU.
//   - pri_e      : round-robin priority pointer state.
// The arbiter never decodes ALUControl; codes (including unused ones)
// travel through as plain 4-bit vectors. The enum gives them readable names.
package alu_share_arbiter_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SUB   = 4'b0001,
    ALU_AND   = 4'b0010,
    ALU_OR    = 4'b0011,
    ALU_XOR   = 4'b0100,
    ALU_SLT   = 4'b0101,
    ALU_SLTU  = 4'b0110,
    ALU_SLL   = 4'b0111,
    ALU_SRL   = 4'b1000,
    ALU_SRA   = 4'b1001,
    ALU_AUIPC = 4'b1110,
    ALU_LUI   = 4'b1111
  } alu_ctrl_e;

  // Which requester wins when both are eligible.
  typedef enum logic {
    PRI0 = 1'b0,
    PRI1 = 1'b1
  } pri_e;

  localparam int unsigned NUM_REQ = 2;

endpackage : alu_share_arbiter_pkg

// File: rtl/alu_share_arbiter_if.sv
// Bus bundle between two ALU requesters, the shared ALU and the arbiter.
//   Requester side : req_valid/req_ready, reqN_ctrl/a/b,
//                    rsp_valid/rsp_ready, rspN_result/zero, gntN_cnt
//   ALU side       : alu_ctrl/alu_a/alu_b out, alu_result/alu_zero back
// modport slave  : the arbiter.
// modport master : requesters plus the shared ALU (the surrounding system).
interface alu_share_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);

  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [3:0]       req0_ctrl;
  logic [3:0]       req1_ctrl;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;

  logic [3:0]       alu_ctrl;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;

  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready;
  logic [WIDTH-1:0] rsp0_result;
  logic [WIDTH-1:0] rsp1_result;
  logic             rsp0_zero;
  logic             rsp1_zero;

  logic [CNT_W-1:0] gnt0_cnt;
  logic [CNT_W-1:0] gnt1_cnt;

  modport slave (
    input  req_valid, req0_ctrl, req1_ctrl, req0_a, req0_b, req1_a, req1_b,
    output req_ready,
    output alu_ctrl, alu_a, alu_b,
    input  alu_result, alu_zero,
    output rsp_valid, rsp0_result, rsp1_result, rsp0_zero, rsp1_zero,
    input  rsp_ready,
    output gnt0_cnt, gnt1_cnt
  );

  modport master (
    output req_valid, req0_ctrl, req1_ctrl, req0_a, req0_b, req1_a, req1_b,
    input  req_ready,
    input  alu_ctrl, alu_a, alu_b,
    output alu_result, alu_zero,
    input  rsp_valid, rsp0_result, rsp1_result, rsp0_zero, rsp1_zero,
    output rsp_ready,
    input  gnt0_cnt, gnt1_cnt
  );

endinterface : alu_share_arbiter_if

// File: rtl/alu_share_arbiter_rsp_slot.sv
// alu_rsp_slot: single-entry response register for one requester.
//   clk, rst     : clock, asynchronous active-low reset
//   load         : capture load_result/load_zero, valid set next cycle
//   consume      : requester takes the entry this cycle
//   load_result  : ALU result to capture
//   load_zero    : ALU zero flag to capture
//   valid        : entry holds an unconsumed response
//   result, zero : captured response
// Load wins over consume, so a same-cycle consume+load keeps valid high and
// sustains one operation per cycle. Data only changes on load.
module alu_rsp_slot #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             consume,
  input  logic [WIDTH-1:0] load_result,
  input  logic             load_zero,
  output logic             valid,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the data registers are reset too, not just valid, because the
      // captured result is visible on the ports and must read 0 after reset.
      valid  <= 1'b0;
      result <= '0;
      zero   <= 1'b0;
    end else if (load) begin
      valid  <= 1'b1;
      result <= load_result;
      zero   <= load_zero;
    end else if (consume && valid) begin
      valid  <= 1'b0;
    end
  end

endmodule : alu_rsp_slot

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: lets two requesters share one combinational ALU.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : alu_share_arbiter_if.slave (requests, ALU drive/return,
//              per-requester response slots, grant counters)
// Each cycle at most one eligible requester is granted; its ctrl/operands
// drive the ALU in that cycle and the ALU result is captured into that
// requester's response slot (visible one cycle later). A requester is
// eligible only if its slot is empty or being drained in the same cycle,
// so a response is never overwritten. Ties go to the pointer, which then
// moves to the other requester.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_share_arbiter_if.slave   bus
);

  pri_e             pri_q;
  pri_e             pri_d;
  logic [1:0]       eligible;
  logic [1:0]       win;
  logic [1:0]       rsp_valid;
  logic [3:0]       alu_ctrl;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [CNT_W-1:0] gnt0_q;
  logic [CNT_W-1:0] gnt1_q;

  // A full slot can accept a new result only if it drains this cycle.
  assign eligible[0] = bus.req_valid[0] && (!rsp_valid[0] || bus.rsp_ready[0]);
  assign eligible[1] = bus.req_valid[1] && (!rsp_valid[1] || bus.rsp_ready[1]);

  // Priority pointer state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pri_q <= PRI0;
    end else begin
      // NOTE: sequential state always uses non-blocking assignment so every
      // flop samples pre-edge values regardless of process ordering.
      pri_q <= pri_d;
    end
  end

  // Grant decision and pointer next state. Grants are suppressed while reset
  // is held so no ready is shown to a requester that cannot be served.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    win   = 2'b00;
    pri_d = pri_q;
    if (rst) begin
      unique case (eligible)
        2'b01:   win = 2'b01;
        2'b10:   win = 2'b10;
        2'b11:   win = (pri_q == PRI0) ? 2'b01 : 2'b10;
        default: win = 2'b00;
      endcase
    end
    if (win[0]) begin
      pri_d = PRI1;
    end else if (win[1]) begin
      pri_d = PRI0;
    end
  end

  // ALU operand mux: idle ALU sees ADD of zeros.
  always_comb begin
    alu_ctrl = 4'b0000;
    alu_a    = '0;
    alu_b    = '0;
    if (win[0]) begin
      alu_ctrl = bus.req0_ctrl;
      alu_a    = bus.req0_a;
      alu_b    = bus.req0_b;
    end else if (win[1]) begin
      alu_ctrl = bus.req1_ctrl;
      alu_a    = bus.req1_a;
      alu_b    = bus.req1_b;
    end
  end

  alu_rsp_slot #(.WIDTH(WIDTH)) u_slot0 (
    .clk         (clk),
    .rst         (rst),
    .load        (win[0]),
    .consume     (bus.rsp_ready[0]),
    .load_result (bus.alu_result),
    .load_zero   (bus.alu_zero),
    .valid       (rsp_valid[0]),
    .result      (bus.rsp0_result),
    .zero        (bus.rsp0_zero)
  );

  alu_rsp_slot #(.WIDTH(WIDTH)) u_slot1 (
    .clk         (clk),
    .rst         (rst),
    .load        (win[1]),
    .consume     (bus.rsp_ready[1]),
    .load_result (bus.alu_result),
    .load_zero   (bus.alu_zero),
    .valid       (rsp_valid[1]),
    .result      (bus.rsp1_result),
    .zero        (bus.rsp1_zero)
  );

  // Saturating acceptance counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt0_q <= '0;
      gnt1_q <= '0;
    end else begin
      if (win[0] && (gnt0_q != '1)) gnt0_q <= gnt0_q + CNT_W'(1);
      if (win[1] && (gnt1_q != '1)) gnt1_q <= gnt1_q + CNT_W'(1);
    end
  end

  assign bus.req_ready = win;
  assign bus.alu_ctrl  = alu_ctrl;
  assign bus.alu_a     = alu_a;
  assign bus.alu_b     = alu_b;
  assign bus.rsp_valid = rsp_valid;
  assign bus.gnt0_cnt  = gnt0_q;
  assign bus.gnt1_cnt  = gnt1_q;

endmodule : alu_share_arbiter

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: a vector table applied one
// cycle per entry, then directed multi-cycle sequences for alternation,
// backpressure, back-to-back service, reset and counter saturation.
module tb_alu_share_arbiter;
  import alu_share_arbiter_pkg::*;

  localparam int WIDTH = 32;
  localparam int CNT_W = 16;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  alu_share_arbiter_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  alu_share_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU, independent of the arbiter.
  logic [WIDTH-1:0] alu_r;
  always_comb begin
    alu_r = '0;
    case (bus.alu_ctrl)
      ALU_ADD:   alu_r = bus.alu_a + bus.alu_b;
      ALU_SUB:   alu_r = bus.alu_a - bus.alu_b;
      ALU_AND:   alu_r = bus.alu_a & bus.alu_b;
      ALU_OR:    alu_r = bus.alu_a | bus.alu_b;
      ALU_XOR:   alu_r = bus.alu_a ^ bus.alu_b;
      ALU_SLT:   alu_r[0] = ($signed(bus.alu_a) < $signed(bus.alu_b));
      ALU_SLTU:  alu_r[0] = (bus.alu_a < bus.alu_b);
      ALU_SLL:   alu_r = bus.alu_a << bus.alu_b[4:0];
      ALU_SRL:   alu_r = bus.alu_a >> bus.alu_b[4:0];
      ALU_SRA:   alu_r = $signed(bus.alu_a) >>> bus.alu_b[4:0];
      ALU_AUIPC: alu_r = bus.alu_a + bus.alu_b;
      ALU_LUI:   alu_r = bus.alu_b;
      default:   alu_r = '0;
    endcase
  end
  assign bus.alu_result = alu_r;
  assign bus.alu_zero   = (alu_r == '0);

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] rv, input logic [1:0] rr,
                       input logic [3:0] c0, input logic [31:0] a0,
                       input logic [31:0] b0, input logic [3:0] c1,
                       input logic [31:0] a1, input logic [31:0] b1);
    bus.req_valid = rv;
    bus.rsp_ready = rr;
    bus.req0_ctrl = c0;
    bus.req0_a    = a0;
    bus.req0_b    = b0;
    bus.req1_ctrl = c1;
    bus.req1_a    = a1;
    bus.req1_b    = b1;
  endtask

  task automatic do_reset();
    drive(2'b00, 2'b00, 4'h0, 0, 0, 4'h0, 0, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  typedef struct {
    logic [1:0]  rv;
    logic [1:0]  rr;
    logic [3:0]  c0;
    logic [31:0] a0;
    logic [31:0] b0;
    logic [3:0]  c1;
    logic [31:0] a1;
    logic [31:0] b1;
    logic [1:0]  e_ready;
    logic [3:0]  e_ctrl;
    logic [31:0] e_a;
    logic [31:0] e_b;
    logic [1:0]  e_rv;
    logic [31:0] e_r0;
    logic        e_z0;
    logic [31:0] e_r1;
    logic        e_z1;
    logic [15:0] e_g0;
    logic [15:0] e_g1;
  } vec_t;

  vec_t vecs[11];

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    drive(2'b00, 2'b00, 4'h0, 0, 0, 4'h0, 0, 0);

    //        rv     rr     c0     a0            b0   c1     a1     b1
    //        ready  ctrl   alu_a         alu_b      rsp_v  r0     z0 r1 z1 g0 g1
    vecs[0]  = '{2'b01, 2'b11, 4'h0, 32'd5, 32'd7, 4'h0, 32'd0, 32'd0,
                 2'b01, 4'h0, 32'd5, 32'd7, 2'b01, 32'd12, 1'b0, 32'd0, 1'b0, 16'd1, 16'd0};
    vecs[1]  = '{2'b00, 2'b11, 4'h0, 32'd0, 32'd0, 4'h0, 32'd0, 32'd0,
                 2'b00, 4'h0, 32'd0, 32'd0, 2'b00, 32'd12, 1'b0, 32'd0, 1'b0, 16'd1, 16'd0};
    vecs[2]  = '{2'b11, 2'b11, 4'h0, 32'd1, 32'd2, 4'h1, 32'd10, 32'd3,
                 2'b10, 4'h1, 32'd10, 32'd3, 2'b10, 32'd12, 1'b0, 32'd7, 1'b0, 16'd1, 16'd1};
    vecs[3]  = '{2'b11, 2'b11, 4'h0, 32'd1, 32'd2, 4'h1, 32'd10, 32'd3,
                 2'b01, 4'h0, 32'd1, 32'd2, 2'b01, 32'd3, 1'b0, 32'd7, 1'b0, 16'd2, 16'd1};
    vecs[4]  = '{2'b11, 2'b01, 4'h2, 32'd6, 32'd3, 4'h4, 32'hF0, 32'hFF,
                 2'b10, 4'h4, 32'hF0, 32'hFF, 2'b10, 32'd3, 1'b0, 32'h0F, 1'b0, 16'd2, 16'd2};
    vecs[5]  = '{2'b01, 2'b00, 4'hA, 32'd3, 32'd4, 4'h0, 32'd0, 32'd0,
                 2'b01, 4'hA, 32'd3, 32'd4, 2'b11, 32'd0, 1'b1, 32'h0F, 1'b0, 16'd3, 16'd2};
    vecs[6]  = '{2'b11, 2'b00, 4'h0, 32'd1, 32'd1, 4'h0, 32'd1, 32'd1,
                 2'b00, 4'h0, 32'd0, 32'd0, 2'b11, 32'd0, 1'b1, 32'h0F, 1'b0, 16'd3, 16'd2};
    vecs[7]  = '{2'b11, 2'b01, 4'h5, 32'hFFFFFFFF, 32'd1, 4'h0, 32'd1, 32'd1,
                 2'b01, 4'h5, 32'hFFFFFFFF, 32'd1, 2'b11, 32'd1, 1'b0, 32'h0F, 1'b0, 16'd4, 16'd2};
    vecs[8]  = '{2'b00, 2'b11, 4'h0, 32'd0, 32'd0, 4'h0, 32'd0, 32'd0,
                 2'b00, 4'h0, 32'd0, 32'd0, 2'b00, 32'd1, 1'b0, 32'h0F, 1'b0, 16'd4, 16'd2};
    vecs[9]  = '{2'b10, 2'b10, 4'h0, 32'd0, 32'd0, 4'h9, 32'h80000000, 32'd4,
                 2'b10, 4'h9, 32'h80000000, 32'd4, 2'b10, 32'd1, 1'b0, 32'hF8000000, 1'b0, 16'd4, 16'd3};
    vecs[10] = '{2'b01, 2'b00, 4'hF, 32'd0, 32'h12345000, 4'h0, 32'd0, 32'd0,
                 2'b01, 4'hF, 32'd0, 32'h12345000, 2'b11, 32'h12345000, 1'b0, 32'hF8000000, 1'b0, 16'd5, 16'd3};

    // Reset state, including ready/ALU suppression while reset is held.
    drive(2'b11, 2'b11, 4'h3, 32'd9, 32'd9, 4'h4, 32'd8, 32'd8);
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", bus.req_ready, 2'b00);
    check("rst_alu_ctrl",  bus.alu_ctrl, 4'h0);
    check("rst_alu_a",     bus.alu_a, 0);
    check("rst_rsp_valid", bus.rsp_valid, 2'b00);
    check("rst_rsp0",      bus.rsp0_result, 0);
    check("rst_gnt0",      bus.gnt0_cnt, 0);
    check("rst_gnt1",      bus.gnt1_cnt, 0);
    do_reset();

    // Table: one vector per cycle, state carries from entry to entry.
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].rv, vecs[i].rr, vecs[i].c0, vecs[i].a0, vecs[i].b0,
            vecs[i].c1, vecs[i].a1, vecs[i].b1);
      #1;
      check($sformatf("v%0d_req_ready", i), bus.req_ready, vecs[i].e_ready);
      check($sformatf("v%0d_alu_ctrl", i),  bus.alu_ctrl,  vecs[i].e_ctrl);
      check($sformatf("v%0d_alu_a", i),     bus.alu_a,     vecs[i].e_a);
      check($sformatf("v%0d_alu_b", i),     bus.alu_b,     vecs[i].e_b);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_rsp_valid", i), bus.rsp_valid,   vecs[i].e_rv);
      check($sformatf("v%0d_rsp0", i),      bus.rsp0_result, vecs[i].e_r0);
      check($sformatf("v%0d_z0", i),        bus.rsp0_zero,   vecs[i].e_z0);
      check($sformatf("v%0d_rsp1", i),      bus.rsp1_result, vecs[i].e_r1);
      check($sformatf("v%0d_z1", i),        bus.rsp1_zero,   vecs[i].e_z1);
      check($sformatf("v%0d_gnt0", i),      bus.gnt0_cnt,    vecs[i].e_g0);
      check($sformatf("v%0d_gnt1", i),      bus.gnt1_cnt,    vecs[i].e_g1);
      @(negedge clk);
    end

    // Alternation with both requesters continuously valid.
    do_reset();
    drive(2'b11, 2'b11, ALU_ADD, 32'd1, 32'd1, ALU_ADD, 32'd2, 32'd2);
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("alt%0d_req_ready", i), bus.req_ready,
            (i % 2 == 0) ? 2'b01 : 2'b10);
      @(posedge clk);
      @(negedge clk);
    end
    check("alt_gnt0", bus.gnt0_cnt, 2);
    check("alt_gnt1", bus.gnt1_cnt, 2);

    // Backpressure on slot 0 while requester 1 keeps being served.
    do_reset();
    drive(2'b01, 2'b00, ALU_SUB, 32'd9, 32'd9, ALU_ADD, 32'd0, 32'd0);
    #1;
    check("bp_acc_ready", bus.req_ready, 2'b01);
    @(posedge clk);
    #1;
    check("bp_rsp_valid", bus.rsp_valid, 2'b01);
    check("bp_z0", bus.rsp0_zero, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(2'b11, 2'b10, ALU_SUB, 32'd9, 32'd9, ALU_ADD, k, 32'd3);
      #1;
      check($sformatf("bp%0d_req_ready", k), bus.req_ready, 2'b10);
      @(posedge clk);
      #1;
      check($sformatf("bp%0d_rsp_valid", k), bus.rsp_valid, 2'b11);
      check($sformatf("bp%0d_z0", k), bus.rsp0_zero, 1'b1);
      check($sformatf("bp%0d_rsp1", k), bus.rsp1_result, k + 3);
    end
    @(negedge clk);
    drive(2'b11, 2'b11, ALU_SUB, 32'd9, 32'd9, ALU_ADD, 32'd5, 32'd3);
    #1;
    check("bp_release_ready", bus.req_ready, 2'b01);
    @(posedge clk);
    #1;
    check("bp_release_rsp_valid", bus.rsp_valid, 2'b01);

    // Requester 1 back to back, one result per cycle.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive(2'b10, 2'b10, ALU_ADD, 0, 0, ALU_ADD, k * 11, 32'd100);
      #1;
      check($sformatf("b2b%0d_req_ready", k), bus.req_ready, 2'b10);
      @(posedge clk);
      #1;
      check($sformatf("b2b%0d_rsp_valid", k), bus.rsp_valid, 2'b10);
      check($sformatf("b2b%0d_rsp1", k), bus.rsp1_result, k * 11 + 100);
      @(negedge clk);
    end

    // Reset one cycle after an acceptance left pending.
    do_reset();
    drive(2'b01, 2'b00, ALU_ADD, 32'd1, 32'd1, ALU_ADD, 0, 0);
    @(posedge clk);
    #1;
    check("mid_rst_pending", bus.rsp_valid, 2'b01);
    @(negedge clk);
    rst = 1'b0;
    drive(2'b11, 2'b00, ALU_ADD, 32'd5, 32'd5, ALU_ADD, 32'd6, 32'd6);
    #1;
    check("mid_rst_rsp_valid", bus.rsp_valid, 2'b00);
    check("mid_rst_gnt0", bus.gnt0_cnt, 0);
    check("mid_rst_req_ready", bus.req_ready, 2'b00);
    check("mid_rst_alu_a", bus.alu_a, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    drive(2'b11, 2'b11, ALU_ADD, 32'd5, 32'd5, ALU_ADD, 32'd6, 32'd6);
    #1;
    check("post_rst_ptr", bus.req_ready, 2'b01);

    // Reset asserted within the accepting cycle: nothing is captured.
    do_reset();
    drive(2'b01, 2'b00, ALU_ADD, 32'd2, 32'd2, ALU_ADD, 0, 0);
    #1;
    check("rst_acc_ready", bus.req_ready, 2'b01);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_acc_rsp_valid", bus.rsp_valid, 2'b00);
    check("rst_acc_gnt0", bus.gnt0_cnt, 0);
    @(negedge clk);
    rst = 1'b1;

    // Counter saturation.
    do_reset();
    drive(2'b01, 2'b01, ALU_ADD, 32'd1, 32'd2, ALU_ADD, 0, 0);
    repeat (65535) @(posedge clk);
    #1;
    check("sat_gnt0_full", bus.gnt0_cnt, 16'hFFFF);
    @(posedge clk);
    #1;
    check("sat_gnt0_hold", bus.gnt0_cnt, 16'hFFFF);
    check("sat_gnt1", bus.gnt1_cnt, 0);
    @(negedge clk);
    drive(2'b00, 2'b00, 4'h0, 0, 0, 4'h0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_alu_share_arbiter
